booth_control: RTL and testbench

BOOTH_CONTROL -- requirements
Module: booth_control

---
 rtl/booth_control.sv | 110 +++++++++++
 tb/tb_booth_control.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/booth_control.sv
// Radix-2 Booth multiplier sequencer: drives the external multiplicand/multiplier
// datapath through N check/add/shift iterations and registers the signed product.
module booth_control #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     Q_LSB,
  input  logic [2*N-1:0] Y,
  output logic [4:0]     mult_control,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int            CW   = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_e;

  // Bit positions inside mult_control, MSB first.
  localparam int LOAD_A  = 4;
  localparam int LOAD_B  = 3;
  localparam int LOAD_AD = 2;
  localparam int SHIFT   = 1;
  localparam int ADD_SUB = 0;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             add_q, add_d;
  logic             done_q, done_d;
  logic [2*N-1:0]   product_q, product_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; reset is asynchronous so the
  // datapath controls drop the instant rst rises, not at the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      add_q     <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      add_q     <= add_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  // NOTE: every signal driven here gets a default before the case statement,
  // otherwise a state that omits it would infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    add_d        = add_q;
    done_d       = 1'b0;
    product_d    = product_q;
    mult_control = '0;
    ready        = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        mult_control[LOAD_A] = 1'b1;
        mult_control[LOAD_B] = 1'b1;
        cnt_d                = '0;
        state_d              = S_CHECK;
      end
      S_CHECK: begin
        // Pair 01 adds the multiplicand, 10 subtracts it; 00/11 only shift.
        add_d   = (Q_LSB == 2'b01);
        state_d = (Q_LSB[1] ^ Q_LSB[0]) ? S_ADD : S_SHIFT;
      end
      S_ADD: begin
        mult_control[LOAD_AD] = 1'b1;
        mult_control[ADD_SUB] = add_q;
        state_d               = S_SHIFT;
      end
      S_SHIFT: begin
        mult_control[SHIFT] = 1'b1;
        cnt_d               = cnt_q + 1'b1;
        state_d             = (cnt_q == LAST) ? S_DONE : S_CHECK;
      end
      S_DONE: begin
        product_d = Y;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_control.sv
// Directed bench for booth_control with a behavioural Booth datapath closing the loop.
module tb_booth_control;

  localparam int N = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [1:0]     q_lsb;
  logic [2*N-1:0] y;
  logic [4:0]     mult_control;
  logic           ready;
  logic           done;
  logic [2*N-1:0] product;

  logic [N-1:0]   a_in, b_in;
  logic [N-1:0]   a_q, hq_q, lq_q;
  logic           qm1_q;

  int n_checks = 0;
  int n_errors = 0;

  booth_control #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .Q_LSB        (q_lsb),
    .Y            (y),
    .mult_control (mult_control),
    .ready        (ready),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath: A register, {HQ, LQ, Q_-1} accumulator/shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0; hq_q <= '0; lq_q <= '0; qm1_q <= 1'b0;
    end else begin
      if (mult_control[4]) a_q <= a_in;
      if (mult_control[3]) begin
        lq_q <= b_in; hq_q <= '0; qm1_q <= 1'b0;
      end
      if (mult_control[2]) hq_q <= mult_control[0] ? hq_q + a_q : hq_q - a_q;
      if (mult_control[1]) {hq_q, lq_q, qm1_q} <= {hq_q[N-1], hq_q, lq_q};
    end
  end

  assign q_lsb = {lq_q[0], qm1_q};
  assign y     = {hq_q, lq_q};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Follows one operation whose start edge has just been (or is about to be)
  // taken; cycle 1 is the LOAD cycle. Stops at the cycle where done is seen.
  task automatic wait_done(input string tag, input int exp_cyc, input int exp_k,
                           input logic [15:0] exp_seq, input logic [15:0] exp_prod,
                           input logic hold);
    int c;
    int k = 0;
    int shifts = 0;
    logic [15:0] seq = '0;
    for (c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check({tag, " load"}, {27'd0, mult_control}, 32'h18);
        check({tag, " done_low"}, {31'd0, done}, 32'd0);
        if (!hold) start = 1'b0;
      end
      if (c == 2) check({tag, " busy"}, {31'd0, ready}, 32'd0);
      if (mult_control[2]) begin
        k++;
        seq = (seq << 1) | {15'd0, mult_control[0]};
      end
      if (mult_control[1]) shifts++;
      if (done) break;
    end
    check({tag, " cycle"}, c, exp_cyc);
    check({tag, " k"}, k, exp_k);
    check({tag, " addsub_seq"}, {16'd0, seq}, {16'd0, exp_seq});
    check({tag, " shifts"}, shifts, N);
    check({tag, " product"}, {16'd0, product}, {16'd0, exp_prod});
    check({tag, " ready"}, {31'd0, ready}, 32'd1);
  endtask

  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
  endtask

  initial begin
    int c;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    #12;
    check("rst ctrl", {27'd0, mult_control}, 32'd0);
    check("rst ready", {31'd0, ready}, 32'd1);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst product", {16'd0, product}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    launch(8'd19, 8'd12);
    wait_done("19x12", 21, 2, 16'b01, 16'd228, 1'b0);
    @(negedge clk);
    check("pulse width", {31'd0, done}, 32'd0);
    check("product hold", {16'd0, product}, 32'd228);

    launch(8'd25, 8'd31);
    wait_done("25x31", 21, 2, 16'b01, 16'd775, 1'b0);

    launch(8'hFF, 8'hFF);
    wait_done("m1xm1", 20, 1, 16'b0, 16'h0001, 1'b0);

    launch(8'h00, 8'h55);
    wait_done("0x55", 27, 8, 16'h0055, 16'h0000, 1'b0);

    // start held through a whole operation, then reused in the done cycle.
    launch(8'd5, 8'd3);
    wait_done("hold1", 21, 2, 16'b01, 16'd15, 1'b1);
    a_in = 8'hFE;
    b_in = 8'd6;
    wait_done("hold2", 21, 2, 16'b01, 16'hFFF4, 1'b0);

    // Asynchronous reset in the middle of an ADD cycle.
    launch(8'd19, 8'd12);
    for (c = 0; c < 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (mult_control[2]) break;
    end
    check("reach add", {31'd0, mult_control[2]}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async ctrl", {27'd0, mult_control}, 32'd0);
    check("async ready", {31'd0, ready}, 32'd1);
    check("async product", {16'd0, product}, 32'd0);
    @(negedge clk);
    check("rst no done", {31'd0, done}, 32'd0);
    rst   = 1'b0;
    a_in  = 8'hFD;
    b_in  = 8'd7;
    start = 1'b1;
    wait_done("post rst", 21, 2, 16'b01, 16'hFFEB, 1'b0);
    @(negedge clk);
    check("final done", {31'd0, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
